// File: rtl/butterfly_arbiter.sv
// Two-requester arbiter in front of one pipelined butterfly, with an in-order tag FIFO for result steering.
// Define BFLY_ARB_FIXED_PRIO_EN to make requester 0 win every contest; the default build is round-robin.
module butterfly_arbiter #(
  parameter int n = 32,
  parameter int D = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_val,
  output logic                     req0_rdy,
  input  logic [6*n-1:0]           req0_msg,
  input  logic                     req1_val,
  output logic                     req1_rdy,
  input  logic [6*n-1:0]           req1_msg,
  output logic                     resp0_val,
  input  logic                     resp0_rdy,
  output logic [4*n-1:0]           resp0_msg,
  output logic                     resp1_val,
  input  logic                     resp1_rdy,
  output logic [4*n-1:0]           resp1_msg,
  output logic                     bf_recv_val,
  input  logic                     bf_recv_rdy,
  output logic [6*n-1:0]           bf_recv_msg,
  input  logic                     bf_send_val,
  output logic                     bf_send_rdy,
  input  logic [4*n-1:0]           bf_send_msg,
  output logic [$clog2(D+1)-1:0]   inflight,
  output logic                     err
);

  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D+1);

  logic          lg_q, lg_d;
  logic [D-1:0]  tag_q, tag_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic full, empty, win, push, pop, head;

  always_comb begin
    full  = (cnt_q == CW'(D));
    empty = (cnt_q == '0);
`ifdef BFLY_ARB_FIXED_PRIO_EN
    win = req1_val & ~req0_val;
`else
    win = (req0_val & req1_val) ? ~lg_q : req1_val;
`endif
    bf_recv_val = (req0_val | req1_val) & ~full;
    bf_recv_msg = win ? req1_msg : req0_msg;
    push        = bf_recv_val & bf_recv_rdy;
    req0_rdy    = push & ~win;
    req1_rdy    = push & win;

    head        = tag_q[rptr_q];
    resp0_val   = bf_send_val & ~empty & ~head;
    resp1_val   = bf_send_val & ~empty & head;
    resp0_msg   = bf_send_msg;
    resp1_msg   = bf_send_msg;
    // An empty FIFO never accepts a result, so a stray one is flagged, not consumed
    bf_send_rdy = ~empty & (head ? resp1_rdy : resp0_rdy);
    pop         = bf_send_val & bf_send_rdy;
  end

  always_comb begin
    lg_d   = lg_q;
    tag_d  = tag_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    err_d  = err_q | (bf_send_val & empty);
    if (push) begin
      lg_d          = win;
      tag_d[wptr_q] = win;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lg_q   <= 1'b1;
      tag_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      lg_q   <= lg_d;
      tag_q  <= tag_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign inflight = cnt_q;
  assign err      = err_q;

endmodule
